// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, active-video
// flag, and a registered RGB332 + sync output stage fed by an external colour mux.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] xIndex,
  output logic [9:0] yIndex,
  output logic       displayEnable,
  input  logic [7:0] color,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       frameTick
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             pix_tick_c;
  logic [CNT_W-1:0] h_next_c;
  logic [CNT_W-1:0] v_next_c;
  logic             de_next_c;
  logic             hs_act_c;
  logic             vs_act_c;

  // Pixel tick fires in the last clock of each divider period.
  assign pix_tick_c = (div == DIV_W'(CLK_DIV - 1));

  // Clock divider: counts 0..CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (pix_tick_c) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Next counter values and flags derived from the current raster position.
  always_comb begin
    h_next_c = xIndex + CNT_W'(1);
    v_next_c = yIndex;
    if (xIndex == CNT_W'(H_TOTAL - 1)) begin
      h_next_c = '0;
      if (yIndex == CNT_W'(V_TOTAL - 1)) begin
        v_next_c = '0;
      end else begin
        v_next_c = yIndex + CNT_W'(1);
      end
    end
    de_next_c = (h_next_c < CNT_W'(H_ACTIVE)) && (v_next_c < CNT_W'(V_ACTIVE));
    hs_act_c  = (xIndex >= CNT_W'(HS_START)) && (xIndex < CNT_W'(HS_END));
    vs_act_c  = (yIndex >= CNT_W'(VS_START)) && (yIndex < CNT_W'(VS_END));
  end

  // Raster counters, active-video flag and frame-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xIndex        <= CNT_W'(H_TOTAL - 1);
      yIndex        <= CNT_W'(V_TOTAL - 1);
      displayEnable <= 1'b0;
      frameTick     <= 1'b0;
    end else begin
      frameTick <= pix_tick_c && (h_next_c == '0) && (v_next_c == '0);
      if (pix_tick_c) begin
        xIndex        <= h_next_c;
        yIndex        <= v_next_c;
        displayEnable <= de_next_c;
      end
    end
  end

  // Pin stage: samples the pre-advance position, so pins trail indices by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (pix_tick_c) begin
      {red, green, blue} <= displayEnable ? color : 8'h00;
      hsync              <= hs_act_c ? SYNC_POL : ~SYNC_POL;
      vsync              <= vs_act_c ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for reset, line timing, colour
// alignment and blanking; a tiny-raster CLK_DIV=1 instance for frame timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  // Full-size instance (CLK_DIV=2)
  logic       rst_a;
  logic [9:0] x_a, y_a;
  logic       de_a, hs_a, vs_a, ft_a;
  logic [2:0] r_a, g_a;
  logic [1:0] b_a;
  logic [7:0] color_a;
  logic       xmode;

  // Colour mux model: either xIndex[7:0], or white in active video and X in blanking.
  assign color_a = xmode ? (de_a ? 8'hFF : 8'hxx) : x_a[7:0];

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .xIndex(x_a), .yIndex(y_a), .displayEnable(de_a),
    .color(color_a), .red(r_a), .green(g_a), .blue(b_a),
    .hsync(hs_a), .vsync(vs_a), .frameTick(ft_a)
  );

  // Tiny raster: H_TOTAL=15 (hsync at 10..12), V_TOTAL=8 (vsync at 5..6), CLK_DIV=1
  logic       rst_b;
  logic [9:0] x_b, y_b;
  logic       de_b, hs_b, vs_b, ft_b;
  logic [2:0] r_b, g_b;
  logic [1:0] b_b;
  logic [7:0] color_b;

  assign color_b = x_b[7:0];

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .xIndex(x_b), .yIndex(y_b), .displayEnable(de_b),
    .color(color_b), .red(r_b), .green(g_b), .blue(b_b),
    .hsync(hs_b), .vsync(vs_b), .frameTick(ft_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // Advance to the given rising-edge count since reset release, then park on the falling edge.
  task automatic advance(input int target);
    while (edges < target) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    xmode = 1'b0;

    // ---------------- Instance A: reset state ----------------
    repeat (5) @(negedge clk);
    check("a_rst_x",   32'(x_a), 32'd799);
    check("a_rst_y",   32'(y_a), 32'd524);
    check("a_rst_hs",  32'(hs_a), 32'd1);
    check("a_rst_vs",  32'(vs_a), 32'd1);
    check("a_rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    check("a_rst_de",  32'(de_a), 32'd0);
    check("a_rst_ft",  32'(ft_a), 32'd0);
    rst_a = 1'b0;
    edges = 0;

    // First pixTick wraps to (0,0) on clk 2
    advance(1);
    check("a_e1_x",  32'(x_a), 32'd799);
    check("a_e1_ft", 32'(ft_a), 32'd0);
    advance(2);
    check("a_e2_x",  32'(x_a), 32'd0);
    check("a_e2_y",  32'(y_a), 32'd0);
    check("a_e2_de", 32'(de_a), 32'd1);
    check("a_e2_ft", 32'(ft_a), 32'd1);
    advance(3);
    check("a_e3_ft", 32'(ft_a), 32'd0);
    check("a_e3_x",  32'(x_a), 32'd0);

    // Colour alignment: pins show the previous xIndex
    advance(4);
    check("a_px0_x",   32'(x_a), 32'd1);
    check("a_px0_rgb", 32'({r_a, g_a, b_a}), 32'h00);
    advance(6);
    check("a_px1_rgb", 32'({r_a, g_a, b_a}), 32'h01);
    advance(8);
    check("a_px2_rgb", 32'({r_a, g_a, b_a}), 32'h02);
    check("a_px2_x",   32'(x_a), 32'd3);

    // Switch to white-in-active / X-in-blanking colour source
    advance(1270);
    xmode = 1'b1;

    // End of active region
    advance(1281);
    check("a_de_639", 32'(de_a), 32'd1);
    advance(1282);
    check("a_de_640", 32'(de_a), 32'd0);
    check("a_x_640",  32'(x_a), 32'd640);
    advance(1283);
    check("a_red_last",   32'(r_a), 32'd7);
    check("a_green_last", 32'(g_a), 32'd7);
    check("a_blue_last",  32'(b_a), 32'd3);
    advance(1284);
    check("a_rgb_blank", 32'({r_a, g_a, b_a}), 32'd0);

    // hsync: low for 192 clk starting one pixel after xIndex reaches 656
    advance(1315);
    check("a_x_656",    32'(x_a), 32'd656);
    check("a_hs_pre",   32'(hs_a), 32'd1);
    advance(1316);
    check("a_hs_start", 32'(hs_a), 32'd0);
    check("a_rgb_sync", 32'({r_a, g_a, b_a}), 32'd0);
    advance(1400);
    check("a_rgb_porch", 32'({r_a, g_a, b_a}), 32'd0);
    advance(1507);
    check("a_hs_last",  32'(hs_a), 32'd0);
    advance(1508);
    check("a_hs_end",   32'(hs_a), 32'd1);

    // Line wrap after 1600 clk
    advance(1601);
    check("a_x_799",  32'(x_a), 32'd799);
    check("a_y_0",    32'(y_a), 32'd0);
    check("a_de_799", 32'(de_a), 32'd0);
    advance(1602);
    check("a_x_wrap", 32'(x_a), 32'd0);
    check("a_y_1",    32'(y_a), 32'd1);
    check("a_de_l1",  32'(de_a), 32'd1);
    check("a_ft_l1",  32'(ft_a), 32'd0);
    check("a_vs_l1",  32'(vs_a), 32'd1);
    advance(1604);
    check("a_rgb_l1", 32'({r_a, g_a, b_a}), 32'hFF);

    // Async reset mid-clk at xIndex=700 (inside hsync)
    advance(3002);
    check("a_x_700",   32'(x_a), 32'd700);
    check("a_hs_700",  32'(hs_a), 32'd0);
    #2 rst_a = 1'b1;
    #1;
    check("a_arst_x",   32'(x_a), 32'd799);
    check("a_arst_y",   32'(y_a), 32'd524);
    check("a_arst_hs",  32'(hs_a), 32'd1);
    check("a_arst_de",  32'(de_a), 32'd0);
    check("a_arst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    edges = 0;
    advance(1);
    check("a_rs_e1_ft", 32'(ft_a), 32'd0);
    check("a_rs_e1_x",  32'(x_a), 32'd799);
    advance(2);
    check("a_rs_e2_ft", 32'(ft_a), 32'd1);
    check("a_rs_e2_x",  32'(x_a), 32'd0);
    check("a_rs_e2_y",  32'(y_a), 32'd0);

    // ---------------- Instance B: tiny raster, CLK_DIV=1 ----------------
    rst_a = 1'b1;
    check("b_rst_x",  32'(x_b), 32'd14);
    check("b_rst_y",  32'(y_b), 32'd7);
    check("b_rst_vs", 32'(vs_b), 32'd1);
    rst_b = 1'b0;
    edges = 0;
    advance(1);
    check("b_e1_ft", 32'(ft_b), 32'd1);
    check("b_e1_x",  32'(x_b), 32'd0);
    check("b_e1_de", 32'(de_b), 32'd1);
    advance(2);
    check("b_e2_ft", 32'(ft_b), 32'd0);
    advance(5);
    check("b_px3_rgb", 32'({r_b, g_b, b_b}), 32'd3);
    advance(11);
    check("b_hs_pre",   32'(hs_b), 32'd1);
    advance(12);
    check("b_hs_start", 32'(hs_b), 32'd0);
    advance(14);
    check("b_hs_last",  32'(hs_b), 32'd0);
    advance(15);
    check("b_hs_end",   32'(hs_b), 32'd1);
    advance(76);
    check("b_y_5",      32'(y_b), 32'd5);
    check("b_vs_pre",   32'(vs_b), 32'd1);
    advance(77);
    check("b_vs_start", 32'(vs_b), 32'd0);
    advance(106);
    check("b_vs_last",  32'(vs_b), 32'd0);
    advance(107);
    check("b_vs_end",   32'(vs_b), 32'd1);
    advance(120);
    check("b_last_x",  32'(x_b), 32'd14);
    check("b_last_y",  32'(y_b), 32'd7);
    check("b_last_ft", 32'(ft_b), 32'd0);
    advance(121);
    check("b_wrap_x",  32'(x_b), 32'd0);
    check("b_wrap_y",  32'(y_b), 32'd0);
    check("b_wrap_ft", 32'(ft_b), 32'd1);
    advance(122);
    check("b_wrap_ft_off", 32'(ft_b), 32'd0);

    // Async reset inside both sync pulses: no partial pulse may persist
    advance(207);
    check("b_mid_x",  32'(x_b), 32'd11);
    check("b_mid_y",  32'(y_b), 32'd5);
    check("b_mid_hs", 32'(hs_b), 32'd0);
    check("b_mid_vs", 32'(vs_b), 32'd0);
    #2 rst_b = 1'b1;
    #1;
    check("b_arst_x",  32'(x_b), 32'd14);
    check("b_arst_y",  32'(y_b), 32'd7);
    check("b_arst_hs", 32'(hs_b), 32'd1);
    check("b_arst_vs", 32'(vs_b), 32'd1);
    check("b_arst_ft", 32'(ft_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    edges = 0;
    advance(1);
    check("b_rs_ft", 32'(ft_b), 32'd1);
    check("b_rs_x",  32'(x_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing: pixel-rate tick, horizontal/vertical counters, active-video flag.
- Drives xIndex/yIndex/displayEnable to the pixel colour mux.
- Samples the mux's 8-bit colour back and drives registered RGB332 and sync pins.
- Top-level display front end; the colour mux sits combinationally between its index outputs and its colour input.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 50 MHz clk -> 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
xIndex  output  10  current horizontal count (0..H_TOTAL-1)
yIndex  output  10  current vertical count (0..V_TOTAL-1)
displayEnable  output  1  high when xIndex<H_ACTIVE and yIndex<V_ACTIVE
color  input  8  RGB332 pixel colour for current xIndex/yIndex
red  output  3  colour[7:5] during active video, else 0
green  output  3  colour[4:2] during active video, else 0
blue  output  2  colour[1:0] during active video, else 0
hsync  output  1  horizontal sync pin
vsync  output  1  vertical sync pin
frameTick  output  1  one-clk pulse at start of each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- One clock; reset is asynchronous and active-high. All outputs registered; none combinational from inputs.
- Divider: counts 0..CLK_DIV-1. pixTick (internal) is high in the clk where divider == CLK_DIV-1. CLK_DIV=1 -> pixTick every clk.
- Counters update on pixTick only; hold otherwise.
  - hCount: increments, wraps H_TOTAL-1 -> 0.
  - vCount: increments only on hCount wrap; wraps V_TOTAL-1 -> 0.
- xIndex/yIndex are hCount/vCount directly.
- displayEnable is registered alongside the counters and always matches the new counter values.
- Output stage, updated on pixTick from pre-advance counter/displayEnable values, so pins lag indices by exactly one pixel period:
  - {red,green,blue} <= displayEnable ? color : 0
  - hsync asserted (=SYNC_POL) iff H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync asserted iff V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC (490..491)
  - color must be stable for the whole pixel period before pixTick; the mux path has CLK_DIV clocks.
- frameTick: high for exactly one clk, on the clk edge where the counters become (0,0); low at all other times.
- Reset values:
  - divider 0
  - xIndex = H_TOTAL-1 (799), yIndex = V_TOTAL-1 (524)
  - displayEnable 0
  - red/green/blue 0
  - hsync = vsync = ~SYNC_POL (deasserted)
  - frameTick 0
- The first pixTick after reset wraps both counters to (0,0): displayEnable -> 1, frameTick pulses. The first pixel is therefore always a clean frame start.
- Reset mid-frame: all state returns immediately (asynchronously) to reset values; no partial sync pulse persists.
- color is ignored while displayEnable=0, including X/undefined values.
- hCount and vCount wrap simultaneously at the last pixel of the frame: a single frameTick, no skipped or double line.

Test Plan:
- Reset, CLK_DIV=2: hold rst 5 clk, release -> xIndex=799, yIndex=524, hsync=vsync=1, RGB=0. On clk 2 after release: xIndex=0, yIndex=0, displayEnable=1, frameTick=1 for exactly 1 clk.
- Line timing: xIndex advances every 2 clk. hsync low for exactly 192 clk, beginning one pixel period after xIndex reaches 656. Line period 1600 clk. displayEnable low from xIndex 640 through 799.
- Frame timing: frameTick period = 840000 clk. vsync low for 2 lines (3200 clk), beginning one pixel period after yIndex reaches 490. yIndex wraps 524 -> 0 in the same clk that xIndex wraps 799 -> 0.
- Blanking: drive color=8'hFF constantly -> red=7, green=7, blue=3 only during the pixel period following displayEnable=1. RGB=0 throughout porches and sync; color=8'hXX during blanking produces no X on pins.
- Colour alignment: color = xIndex[7:0] -> at each pixTick, {red,green,blue} equals the previous xIndex value. First visible line begins with 0x00, 0x01, 0x02.
- Async reset at xIndex=700, yIndex=100, mid-clk: outputs return to reset values before the next edge. Restart produces frameTick 2 clk after release. Repeat with CLK_DIV=1: frameTick period 420000 clk.
